// File: rtl/prog_ctr_fetch.sv
// Program counter / fetch sequencer feeding the instruction ROM address.
// Handles fall-through, LUT-based absolute branches, relative branches, stall and halt.
module prog_ctr_fetch #(
  parameter int unsigned A     = 12,
  parameter int unsigned OFS_W = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [A-1:0]     StartAddr,
  input  logic             Stall,
  input  logic             BranchAbs,
  input  logic [2:0]       LutIdx,
  input  logic             BranchRel,
  input  logic [OFS_W-1:0] Offset,
  input  logic             Halt,
  input  logic             LutWe,
  input  logic [2:0]       LutWIdx,
  input  logic [A-1:0]     LutWData,
  output logic [A-1:0]     ProgCtr,
  output logic             Running,
  output logic             Done
);

  localparam int unsigned LUT_N = 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [A-1:0]   pc_q, pc_d;
  logic [A-1:0]   lut_q [LUT_N];
  logic [A-1:0]   lut_d [LUT_N];
  logic [A-1:0]   ofs_ext;

  // State, program counter and branch-target LUT registers
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      lut_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      lut_q   <= lut_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (Start) state_d = S_RUN;
      S_RUN: begin
        if (Start)     state_d = S_RUN;
        else if (Halt) state_d = S_HALTED;
      end
      S_HALTED: if (Start) state_d = S_RUN;
      default:  state_d = S_IDLE;
    endcase
  end

  assign ofs_ext = A'(signed'(Offset));

  // Next program counter and LUT write; branch reads see the pre-write LUT
  always_comb begin
    pc_d  = pc_q;
    lut_d = lut_q;
    if (LutWe) lut_d[LutWIdx] = LutWData;
    case (state_q)
      S_RUN: begin
        if (Start)          pc_d = StartAddr;
        else if (Halt)      pc_d = pc_q;
        else if (Stall)     pc_d = pc_q;
        else if (BranchAbs) pc_d = lut_q[LutIdx];
        else if (BranchRel) pc_d = pc_q + ofs_ext;
        else                pc_d = pc_q + A'(1);
      end
      S_IDLE, S_HALTED: if (Start) pc_d = StartAddr;
      default:          pc_d = pc_q;
    endcase
  end

  assign ProgCtr = pc_q;
  assign Running = (state_q == S_RUN);
  assign Done    = (state_q == S_HALTED);

endmodule

// File: tb/tb_prog_ctr_fetch.sv
// Directed bench for prog_ctr_fetch: expected PC/status pushed to a scoreboard on drive, checked after the edge.
module tb_prog_ctr_fetch;

  localparam int unsigned A     = 12;
  localparam int unsigned OFS_W = 8;

  logic             Clk = 1'b0;
  logic             Reset_n;
  logic             Start;
  logic [A-1:0]     StartAddr;
  logic             Stall;
  logic             BranchAbs;
  logic [2:0]       LutIdx;
  logic             BranchRel;
  logic [OFS_W-1:0] Offset;
  logic             Halt;
  logic             LutWe;
  logic [2:0]       LutWIdx;
  logic [A-1:0]     LutWData;
  logic [A-1:0]     ProgCtr;
  logic             Running;
  logic             Done;

  typedef struct packed {
    logic [A-1:0] pc;
    logic         running;
    logic         done;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  prog_ctr_fetch #(.A(A), .OFS_W(OFS_W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .StartAddr(StartAddr),
    .Stall(Stall), .BranchAbs(BranchAbs), .LutIdx(LutIdx), .BranchRel(BranchRel),
    .Offset(Offset), .Halt(Halt), .LutWe(LutWe), .LutWIdx(LutWIdx),
    .LutWData(LutWData), .ProgCtr(ProgCtr), .Running(Running), .Done(Done)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic clr();
    Start = 1'b0; StartAddr = '0; Stall = 1'b0; BranchAbs = 1'b0; LutIdx = '0;
    BranchRel = 1'b0; Offset = '0; Halt = 1'b0; LutWe = 1'b0; LutWIdx = '0;
    LutWData = '0;
  endtask

  // Push the expectation, clock once, then pop and compare
  task automatic step(input string tag, input logic [A-1:0] pc, input logic run,
                      input logic done);
    exp_t e;
    exp_t obs;
    string t;
    sb_q.push_back('{pc: pc, running: run, done: done});
    tag_q.push_back(tag);
    @(posedge Clk);
    #1;
    e   = sb_q.pop_front();
    t   = tag_q.pop_front();
    obs = '{pc: ProgCtr, running: Running, done: Done};
    n_cmp++;
    assert (obs === e) else begin
      n_err++;
      $error("FAIL %s: observed pc=%0d run=%0b done=%0b, expected pc=%0d run=%0b done=%0b",
             t, obs.pc, obs.running, obs.done, e.pc, e.running, e.done);
    end
  endtask

  initial begin
    clr();
    Reset_n = 1'b0;
    // Reset with random inputs
    for (int i = 0; i < 2; i++) begin
      Start = 1'($urandom); StartAddr = A'($urandom); Stall = 1'($urandom);
      BranchAbs = 1'($urandom); LutIdx = 3'($urandom); BranchRel = 1'($urandom);
      Offset = OFS_W'($urandom); Halt = 1'($urandom); LutWe = 1'($urandom);
      LutWIdx = 3'($urandom); LutWData = A'($urandom);
      step("reset", 12'd0, 1'b0, 1'b0);
    end
    Reset_n = 1'b1; clr();
    Halt = 1'b1; BranchAbs = 1'b1; step("idle_ignore", 12'd0, 1'b0, 1'b0);
    clr(); Start = 1'b1; StartAddr = 12'd10; step("start10", 12'd10, 1'b1, 1'b0);
    clr(); step("fall11", 12'd11, 1'b1, 1'b0);
    step("fall12", 12'd12, 1'b1, 1'b0);

    // LUT write then absolute branch
    LutWe = 1'b1; LutWIdx = 3'd3; LutWData = 12'h200; step("lut_wr", 12'd13, 1'b1, 1'b0);
    clr(); BranchAbs = 1'b1; LutIdx = 3'd3; step("babs", 12'h200, 1'b1, 1'b0);
    clr(); step("fall_201", 12'h201, 1'b1, 1'b0);
    BranchAbs = 1'b1; LutIdx = 3'd3; LutWe = 1'b1; LutWIdx = 3'd3; LutWData = 12'h300;
    step("wr_rd_same", 12'h200, 1'b1, 1'b0);
    clr(); step("after_same", 12'h201, 1'b1, 1'b0);
    BranchAbs = 1'b1; LutIdx = 3'd3; step("babs_new", 12'h300, 1'b1, 1'b0);

    // Relative branches and wrap
    clr(); Start = 1'b1; StartAddr = 12'd2; step("start2", 12'd2, 1'b1, 1'b0);
    clr(); BranchRel = 1'b1; Offset = 8'hFB; step("rel_neg5", 12'd4093, 1'b1, 1'b0);
    clr(); Start = 1'b1; StartAddr = 12'd4095; step("start4095", 12'd4095, 1'b1, 1'b0);
    clr(); step("wrap0", 12'd0, 1'b1, 1'b0);
    Start = 1'b1; StartAddr = 12'd4090; step("start4090", 12'd4090, 1'b1, 1'b0);
    clr(); BranchRel = 1'b1; Offset = 8'd127; step("rel_127", 12'd121, 1'b1, 1'b0);

    // Stall and branch priority
    clr(); Start = 1'b1; StartAddr = 12'd20; step("start20", 12'd20, 1'b1, 1'b0);
    clr(); Stall = 1'b1;
    for (int i = 0; i < 3; i++) step("stall", 12'd20, 1'b1, 1'b0);
    BranchAbs = 1'b1; LutIdx = 3'd3; step("stall_babs", 12'd20, 1'b1, 1'b0);
    clr(); BranchAbs = 1'b1; BranchRel = 1'b1; LutIdx = 3'd3; Offset = 8'd5;
    step("abs_over_rel", 12'h300, 1'b1, 1'b0);
    clr(); Start = 1'b1; Halt = 1'b1; StartAddr = 12'd600;
    step("start_over_halt", 12'd600, 1'b1, 1'b0);

    // Halt and restart
    clr(); Start = 1'b1; StartAddr = 12'd37; step("start37", 12'd37, 1'b1, 1'b0);
    clr(); Halt = 1'b1; BranchAbs = 1'b1; LutIdx = 3'd3; step("halt", 12'd37, 1'b0, 1'b1);
    clr(); BranchAbs = 1'b1; LutIdx = 3'd3; step("halted_babs", 12'd37, 1'b0, 1'b1);
    clr(); Stall = 1'b1; BranchRel = 1'b1; Offset = 8'd9; step("halted_rel", 12'd37, 1'b0, 1'b1);
    clr(); step("halted_idle", 12'd37, 1'b0, 1'b1);
    Start = 1'b1; StartAddr = 12'd0; step("restart0", 12'd0, 1'b1, 1'b0);

    // Reset in the middle of RUN
    clr(); Start = 1'b1; StartAddr = 12'd500; step("start500", 12'd500, 1'b1, 1'b0);
    clr(); step("fall501", 12'd501, 1'b1, 1'b0);
    Reset_n = 1'b0; Start = 1'b1; StartAddr = 12'd77; LutWe = 1'b1; LutWIdx = 3'd3;
    LutWData = 12'h555; step("mid_reset", 12'd0, 1'b0, 1'b0);
    Reset_n = 1'b1; clr(); step("idle_after", 12'd0, 1'b0, 1'b0);
    Start = 1'b1; StartAddr = 12'd7; step("start7", 12'd7, 1'b1, 1'b0);
    clr(); BranchAbs = 1'b1; LutIdx = 3'd3; step("lut_cleared", 12'd0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
